// File: rtl/msx_slot_mapper.sv
// MSX slot and memory-mapper controller: primary slot register (A8h), subslot
// registers at FFFFh for expanded slots, and RAM mapper segment registers (FCh-FFh).
module msx_slot_mapper #(
  parameter int unsigned SEG_BITS = 3,
  parameter logic [3:0]  EXPANDED = 4'b1000,
  parameter int unsigned RAM_SLOT = 3,
  parameter int unsigned RAM_SUB  = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            addr,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   dout_oe,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   m1_n,
  input  logic                   rfrsh_n,
  output logic [3:0]             SLTSL_n,
  output logic [15:0]            SUBSL_n,
  output logic                   ram_cs_n,
  output logic [SEG_BITS+13:0]   ram_addr
);

  localparam logic [1:0] RAM_SLOT_L = 2'(RAM_SLOT);
  localparam logic [1:0] RAM_SUB_L  = 2'(RAM_SUB);

  logic [7:0]          prim_q, prim_d;
  logic [7:0]          sub_q [4];
  logic [7:0]          sub_d [4];
  logic [SEG_BITS-1:0] seg_q [4];
  logic [SEG_BITS-1:0] seg_d [4];
  logic                io_wr_prev_q, io_wr_prev_d;
  logic                mem_wr_prev_q, mem_wr_prev_d;

  logic [1:0] pg;
  logic [1:0] ps;
  logic [1:0] ss;
  logic       ps_exp;
  logic       mem;
  logic       addr_ffff;
  logic       sel;
  logic       io_cyc;
  logic       io_wr;
  logic       mem_wr;
  logic       io_wr_fire;
  logic       mem_wr_fire;
  logic [1:0] pg3_slot;
  logic       pg3_exp;
  logic       port_a8;
  logic       port_map;

  // Bus decode: page -> primary slot -> secondary slot
  always_comb begin
    pg        = addr[15:14];
    ps        = prim_q[{pg, 1'b0} +: 2];
    ps_exp    = EXPANDED[ps];
    ss        = ps_exp ? sub_q[ps][{pg, 1'b0} +: 2] : 2'b00;
    mem       = ~mreq_n & rfrsh_n;
    addr_ffff = &addr;
    // The subslot register shadows FFFFh of an expanded slot
    sel       = mem & ~(addr_ffff & ps_exp);
    pg3_slot  = prim_q[7:6];
    pg3_exp   = EXPANDED[pg3_slot];
    io_cyc    = ~iorq_n & m1_n;
    io_wr     = io_cyc & ~wr_n;
    mem_wr    = mem & ~wr_n;
    port_a8   = (addr[7:0] == 8'hA8);
    port_map  = (addr[7:2] == 6'b111111);
  end

  always_comb begin
    SLTSL_n = '1;
    SUBSL_n = '1;
    if (sel) begin
      SLTSL_n[ps] = 1'b0;
      if (ps_exp) begin
        SUBSL_n[{ps, ss}] = 1'b0;
      end
    end
    ram_cs_n = ~(sel & (ps == RAM_SLOT_L) & (~ps_exp | (ss == RAM_SUB_L)));
    ram_addr = {seg_q[pg], addr[13:0]};
  end

  always_comb begin
    dout    = '1;
    dout_oe = 1'b0;
    if (io_cyc & ~rd_n & port_a8) begin
      dout    = prim_q;
      dout_oe = 1'b1;
    end else if (io_cyc & ~rd_n & port_map) begin
      dout[SEG_BITS-1:0] = seg_q[addr[1:0]];
      dout_oe = 1'b1;
    end else if (mem & ~rd_n & addr_ffff & pg3_exp) begin
      dout    = ~sub_q[pg3_slot];
      dout_oe = 1'b1;
    end
  end

  // Rising-edge write detection; an I/O write masks a simultaneous memory write
  always_comb begin
    io_wr_fire    = io_wr & ~io_wr_prev_q;
    mem_wr_fire   = mem_wr & ~mem_wr_prev_q & ~io_wr;
    io_wr_prev_d  = io_wr;
    mem_wr_prev_d = mem_wr;
    prim_d        = prim_q;
    sub_d         = sub_q;
    seg_d         = seg_q;
    if (io_wr_fire) begin
      if (port_a8) begin
        prim_d = din;
      end else if (port_map) begin
        seg_d[addr[1:0]] = din[SEG_BITS-1:0];
      end
    end else if (mem_wr_fire & addr_ffff & pg3_exp) begin
      sub_d[pg3_slot] = din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prim_q        <= '0;
      io_wr_prev_q  <= 1'b1;
      mem_wr_prev_q <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        sub_q[i] <= '0;
        seg_q[i] <= SEG_BITS'(3 - i);
      end
    end else begin
      prim_q        <= prim_d;
      sub_q         <= sub_d;
      seg_q         <= seg_d;
      io_wr_prev_q  <= io_wr_prev_d;
      mem_wr_prev_q <= mem_wr_prev_d;
    end
  end

endmodule

// File: tb/tb_msx_slot_mapper.sv
// Directed bench for msx_slot_mapper: transaction-level register model checked
// against all outputs every cycle, plus hand-computed literal expectations.
module tb_msx_slot_mapper;

  localparam int unsigned SEG_BITS = 3;
  localparam logic [3:0]  EXPANDED = 4'b1000;
  localparam int unsigned RAM_SLOT = 3;
  localparam int unsigned RAM_SUB  = 0;
  localparam int          SEG_MOD  = 1 << SEG_BITS;

  logic                 clk;
  logic                 reset_n;
  logic [15:0]          addr;
  logic [7:0]           din;
  logic [7:0]           dout;
  logic                 dout_oe;
  logic                 mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n;
  logic [3:0]           SLTSL_n;
  logic [15:0]          SUBSL_n;
  logic                 ram_cs_n;
  logic [SEG_BITS+13:0] ram_addr;

  msx_slot_mapper #(
    .SEG_BITS(SEG_BITS),
    .EXPANDED(EXPANDED),
    .RAM_SLOT(RAM_SLOT),
    .RAM_SUB (RAM_SUB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
    .dout_oe(dout_oe), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .m1_n(m1_n), .rfrsh_n(rfrsh_n), .SLTSL_n(SLTSL_n),
    .SUBSL_n(SUBSL_n), .ram_cs_n(ram_cs_n), .ram_addr(ram_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_prim;
  int m_sub [4];
  int m_seg [4];
  logic [3:0] wr_sltsl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prim = 0;
    for (int i = 0; i < 4; i++) begin
      m_sub[i] = 0;
      m_seg[i] = (3 - i) % SEG_MOD;
    end
  endtask

  // One accepted write, applied with the architectural meaning of each target
  task automatic model_write(input bit io, input int a, input int d);
    int slot;
    if (io) begin
      if ((a % 256) == 'hA8) m_prim = d;
      else if ((a % 256) >= 'hFC) m_seg[(a % 256) - 'hFC] = d % SEG_MOD;
    end else begin
      slot = m_prim / 64;
      if (a == 'hFFFF && EXPANDED[slot]) m_sub[slot] = d;
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int pg, ps, ss, a;
    bit xp, active, io_rd;
    logic [3:0]  e_sl;
    logic [15:0] e_sub;
    logic        e_cs;
    logic [7:0]  e_dout;
    logic        e_oe;
    a      = int'(addr);
    pg     = a / 16384;
    ps     = (m_prim >> (2 * pg)) % 4;
    xp     = EXPANDED[ps];
    ss     = xp ? (m_sub[ps] >> (2 * pg)) % 4 : 0;
    active = !mreq_n && rfrsh_n && !(a == 'hFFFF && xp);
    e_sl   = 4'hF;
    e_sub  = 16'hFFFF;
    if (active) begin
      e_sl[ps] = 1'b0;
      if (xp) e_sub[ps * 4 + ss] = 1'b0;
    end
    e_cs   = !(active && ps == RAM_SLOT && (!xp || ss == RAM_SUB));
    io_rd  = !iorq_n && m1_n && !rd_n;
    e_oe   = 1'b1;
    if (io_rd && (a % 256) == 'hA8) e_dout = 8'(m_prim);
    else if (io_rd && (a % 256) >= 'hFC) e_dout = 8'(256 - SEG_MOD + m_seg[(a % 256) - 'hFC]);
    else if (!mreq_n && rfrsh_n && !rd_n && a == 'hFFFF && EXPANDED[m_prim / 64])
      e_dout = 8'(255 - m_sub[m_prim / 64]);
    else begin
      e_dout = 8'hFF;
      e_oe   = 1'b0;
    end
    chk("SLTSL_n", 32'(SLTSL_n), 32'(e_sl));
    chk("SUBSL_n", 32'(SUBSL_n), 32'(e_sub));
    chk("ram_cs_n", 32'(ram_cs_n), 32'(e_cs));
    chk("ram_addr", 32'(ram_addr), 32'(m_seg[pg] * 16384 + a % 16384));
    chk("dout_oe", 32'(dout_oe), 32'(e_oe));
    chk("dout", 32'(dout), 32'(e_dout));
  end

  task automatic bus_idle();
    iorq_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfrsh_n = 1'b1;
  endtask

  task automatic bus_write(input bit io, input bit mem, input logic [15:0] a,
                           input logic [7:0] d, input int hold, input bit m1, input bit rf);
    @(posedge clk); #1;
    addr = a; din = d; m1_n = m1; rfrsh_n = rf;
    iorq_n = !io; mreq_n = !mem; wr_n = 1'b0;
    @(posedge clk);
    if (io && m1) model_write(1'b1, int'(a), int'(d));
    else if (!io && mem && rf) model_write(1'b0, int'(a), int'(d));
    @(negedge clk);
    wr_sltsl = SLTSL_n;
    repeat (hold - 1) @(posedge clk);
    #1 bus_idle();
  endtask

  task automatic io_read(input string name, input logic [15:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    addr = a; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    chk(name, {23'd0, dout_oe, dout}, {23'd0, 1'b1, exp});
    @(posedge clk); #1 bus_idle();
  endtask

  task automatic mem_read_begin(input logic [15:0] a);
    @(posedge clk); #1;
    addr = a; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    bus_idle();
    addr = 16'h00A8; din = 8'h55;
    iorq_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus_idle(); addr = 16'h0000;
    @(negedge clk);
    chk("idle_sltsl", 32'(SLTSL_n), 32'hF);
    chk("idle_subsl", 32'(SUBSL_n), 32'hFFFF);
    chk("idle_ramcs", 32'(ram_cs_n), 32'h1);
    chk("idle_dout", {23'd0, dout_oe, dout}, {23'd0, 9'h0FF});
    io_read("rst_prim", 16'h00A8, 8'h00);
    io_read("rst_seg0", 16'h00FC, 8'hFB);

    // Primary slot write held 5 clocks
    bus_write(1, 0, 16'h00A8, 8'hC0, 5, 1, 1);
    io_read("prim_c0", 16'h00A8, 8'hC0);
    mem_read_begin(16'hC000);
    chk("c000_sltsl", 32'(SLTSL_n), 32'h7);
    chk("c000_subsl", 32'(SUBSL_n), 32'hEFFF);
    mem_read_begin(16'h0000);
    chk("0000_sltsl", 32'(SLTSL_n), 32'hE);
    chk("0000_subsl", 32'(SUBSL_n), 32'hFFFF);
    @(posedge clk); #1 bus_idle();

    // Subslot register
    bus_write(0, 1, 16'hFFFF, 8'h40, 2, 1, 1);
    chk("ffff_wr_sltsl", 32'(wr_sltsl), 32'hF);
    mem_read_begin(16'hFFFF);
    chk("ffff_rd", {23'd0, dout_oe, dout}, {23'd0, 9'h1BF});
    chk("ffff_rd_sltsl", 32'(SLTSL_n), 32'hF);
    mem_read_begin(16'hC000);
    chk("c000_sub13", 32'(SUBSL_n), 32'hDFFF);
    @(posedge clk); #1 bus_idle();

    // Mapper
    bus_write(1, 0, 16'h00A8, 8'hFF, 1, 1, 1);
    bus_write(0, 1, 16'hFFFF, 8'h00, 1, 1, 1);
    bus_write(1, 0, 16'h00FE, 8'h05, 3, 1, 1);
    mem_read_begin(16'h8123);
    chk("8123_cs", 32'(ram_cs_n), 32'h0);
    chk("8123_addr", 32'(ram_addr), 32'h14123);
    @(posedge clk); #1 bus_idle();
    bus_write(1, 0, 16'h00FE, 8'h0D, 2, 1, 1);
    io_read("seg2_wrap", 16'h00FE, 8'hFD);
    chk("model_seg2", 32'(m_seg[2]), 32'd5);
    mem_read_begin(16'h8123);
    chk("8123_addr_wrap", 32'(ram_addr), 32'h14123);
    @(posedge clk); #1 bus_idle();

    // Refresh suppresses all selects
    @(posedge clk); #1;
    addr = 16'h8123; mreq_n = 1'b0; rfrsh_n = 1'b0;
    @(negedge clk);
    chk("rfsh_sltsl", 32'(SLTSL_n), 32'hF);
    chk("rfsh_subsl", 32'(SUBSL_n), 32'hFFFF);
    chk("rfsh_cs", 32'(ram_cs_n), 32'h1);
    @(posedge clk); #1 bus_idle();

    // Interrupt acknowledge ignored
    bus_write(1, 0, 16'h00FC, 8'h06, 2, 0, 1);
    io_read("intack_seg0", 16'h00FC, 8'hFB);

    // Simultaneous I/O and memory write to FFFFh: I/O wins
    bus_write(1, 1, 16'hFFFF, 8'h26, 2, 1, 1);
    io_read("both_seg3", 16'h00FF, 8'hFE);
    mem_read_begin(16'hFFFF);
    chk("both_sub3", {23'd0, dout_oe, dout}, {23'd0, 9'h1FF});
    @(posedge clk); #1 bus_idle();

    // Back-to-back primary writes
    bus_write(1, 0, 16'h00A8, 8'h1B, 1, 1, 1);
    bus_write(1, 0, 16'h00A8, 8'hE4, 1, 1, 1);
    io_read("b2b_prim", 16'h00A8, 8'hE4);

    // Asynchronous reset during held OUT FDh
    @(posedge clk); #1;
    addr = 16'h00FD; din = 8'h07; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    model_write(1'b1, 'hFD, 'h07);
    #2 reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus_idle();
    io_read("arst_seg1", 16'h00FD, 8'hFA);
    io_read("arst_prim", 16'h00A8, 8'h00);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
